fmesh_destp_encoder: RTL and testbench

// - Pipelined route computation for the fmesh topology. Converts a head flit's destination endpoint address into the 4-bit coded destination port {x,y,a,b} plus local port number consumed by fmesh_destp_decoder.
// - Encoder side of that code; sits in the router input port ahead of the lookahead route register. Also emits hop distance.

---
 rtl/fmesh_destp_encoder.sv | 181 ++++++++++++++++++
 tb/tb_fmesh_destp_encoder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fmesh_destp_encoder.sv
// rtl/fmesh_destp_encoder.sv - two-stage fmesh route encoder: endpoint address to {x,y,a,b} port code, local port and hop distance
// Optional per-result address range check enabled by defining FMESH_DESTP_ERR_EN.
module fmesh_destp_encoder #(
  parameter int    NX         = 4,
  parameter int    NY         = 4,
  parameter int    NL         = 1,
  parameter string ROUTE_TYPE = "DETERMINISTIC",
  parameter int    TAGw       = 4,
  localparam int   P          = 5 + NL - 1,
  localparam int   EXw        = (NX > 1) ? $clog2(NX) : 1,
  localparam int   EYw        = (NY > 1) ? $clog2(NY) : 1,
  localparam int   EPw        = $clog2(P),
  localparam int   EAw        = EPw + EYw + EXw,
  localparam int   DISTw      = EXw + EYw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [EXw-1:0]   cur_rx,
  input  logic [EYw-1:0]   cur_ry,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EAw-1:0]   in_e_addr,
  input  logic [TAGw-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_destp,
  output logic [EPw-1:0]   out_localp,
  output logic [DISTw-1:0] out_dist,
  output logic [TAGw-1:0]  out_tag,
  output logic             out_err
);

  localparam bit ADAPTIVE = (ROUTE_TYPE != "DETERMINISTIC");

  logic           rst_done;
  logic           s1_v;
  logic           s1_en;
  logic           s2_en;

  logic           s1_dx_gt;
  logic           s1_dx_ne;
  logic           s1_dy_lt;
  logic           s1_dy_ne;
  logic [EXw-1:0] s1_adx;
  logic [EYw-1:0] s1_ady;
  logic [EPw-1:0] s1_ep;
  logic [TAGw-1:0] s1_tag;

  logic [EXw-1:0] in_ex;
  logic [EYw-1:0] in_ey;
  logic [EPw-1:0] in_ep;
  logic           in_dx_gt;
  logic           in_dy_lt;
  logic [EXw-1:0] in_adx;
  logic [EYw-1:0] in_ady;

  logic           route_a;
  logic           route_b;
  logic [3:0]     destp_c;
  logic [EPw-1:0] localp_c;
  logic [DISTw-1:0] dist_c;

  // Stages advance whenever the stage ahead is empty or draining, so bubbles collapse.
  assign s2_en    = !out_valid || out_ready;
  assign s1_en    = !s1_v || s2_en;
  assign in_ready = rst_done && s1_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rst_done <= 1'b0;
    else       rst_done <= 1'b1;
  end

  assign in_ex = in_e_addr[EXw-1:0];
  assign in_ey = in_e_addr[EXw +: EYw];
  assign in_ep = in_e_addr[EXw+EYw +: EPw];

  // Magnitudes always subtract the smaller from the larger so nothing wraps.
  always_comb begin
    in_dx_gt = (in_ex > cur_rx);
    in_dy_lt = (in_ey < cur_ry);
    in_adx   = in_dx_gt ? (in_ex - cur_rx) : (cur_rx - in_ex);
    in_ady   = in_dy_lt ? (cur_ry - in_ey) : (in_ey - cur_ry);
  end

`ifdef FMESH_DESTP_ERR_EN
  localparam logic [EXw:0] XMAX = (EXw+1)'(NX - 1);
  localparam logic [EYw:0] YMAX = (EYw+1)'(NY - 1);
  localparam logic [EPw:0] PMAX = (EPw+1)'(P - 1);

  logic in_err;
  logic s1_err;

  assign in_err = ({1'b0, in_ex} > XMAX) || ({1'b0, in_ey} > YMAX) || ({1'b0, in_ep} > PMAX);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v     <= 1'b0;
      s1_dx_gt <= 1'b0;
      s1_dx_ne <= 1'b0;
      s1_dy_lt <= 1'b0;
      s1_dy_ne <= 1'b0;
      s1_adx   <= '0;
      s1_ady   <= '0;
      s1_ep    <= '0;
      s1_tag   <= '0;
`ifdef FMESH_DESTP_ERR_EN
      s1_err   <= 1'b0;
`endif
    end else if (s1_en) begin
      s1_v <= in_valid && rst_done;
      if (in_valid && rst_done) begin
        s1_dx_gt <= in_dx_gt;
        s1_dx_ne <= (in_ex != cur_rx);
        s1_dy_lt <= in_dy_lt;
        s1_dy_ne <= (in_ey != cur_ry);
        s1_adx   <= in_adx;
        s1_ady   <= in_ady;
        s1_ep    <= in_ep;
        s1_tag   <= in_tag;
`ifdef FMESH_DESTP_ERR_EN
        s1_err   <= in_err;
`endif
      end
    end
  end

  // XY goes x first; the adaptive build offers both dimensions when both remain.
  always_comb begin
    route_a = 1'b0;
    route_b = 1'b0;
    if (ADAPTIVE && s1_dx_ne && s1_dy_ne) begin
      route_a = 1'b1;
      route_b = 1'b1;
    end else if (s1_dx_ne) begin
      route_a = 1'b1;
    end else if (s1_dy_ne) begin
      route_b = 1'b1;
    end
  end

  always_comb begin
    destp_c  = {route_a & s1_dx_gt, route_b & s1_dy_lt, route_a, route_b};
    localp_c = (!route_a && !route_b) ? s1_ep : '0;
    dist_c   = DISTw'(s1_adx) + DISTw'(s1_ady) + DISTw'(1);
`ifdef FMESH_DESTP_ERR_EN
    if (s1_err) begin
      destp_c  = 4'b0000;
      localp_c = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_destp  <= '0;
      out_localp <= '0;
      out_dist   <= '0;
      out_tag    <= '0;
    end else if (s2_en) begin
      out_valid <= s1_v;
      if (s1_v) begin
        out_destp  <= destp_c;
        out_localp <= localp_c;
        out_dist   <= dist_c;
        out_tag    <= s1_tag;
      end
    end
  end

`ifdef FMESH_DESTP_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 out_err <= 1'b0;
    else if (s2_en && s1_v)    out_err <= s1_err;
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_fmesh_destp_encoder.sv
// tb/tb_fmesh_destp_encoder.sv - directed bench for fmesh_destp_encoder, XY and adaptive builds side by side at cur=(1,2)
module tb_fmesh_destp_encoder;

  logic       clk;
  logic       reset;
  logic [1:0] cur_rx;
  logic [1:0] cur_ry;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_e_addr;
  logic [3:0] in_tag;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_destp;
  logic [2:0] out_localp;
  logic [3:0] out_dist;
  logic [3:0] out_tag;
  logic       out_err;

  logic       ad_in_ready;
  logic       ad_out_valid;
  logic [3:0] ad_out_destp;
  logic [2:0] ad_out_localp;
  logic [3:0] ad_out_dist;
  logic [3:0] ad_out_tag;
  logic       ad_out_err;

  int n_checks = 0;
  int n_errors = 0;

  fmesh_destp_encoder #(.NX(4), .NY(4), .NL(1), .ROUTE_TYPE("DETERMINISTIC"), .TAGw(4)) u_xy (
    .clk(clk), .reset(reset), .cur_rx(cur_rx), .cur_ry(cur_ry),
    .in_valid(in_valid), .in_ready(in_ready), .in_e_addr(in_e_addr), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_destp(out_destp),
    .out_localp(out_localp), .out_dist(out_dist), .out_tag(out_tag), .out_err(out_err)
  );

  fmesh_destp_encoder #(.NX(4), .NY(4), .NL(1), .ROUTE_TYPE("ADAPTIVE"), .TAGw(4)) u_ad (
    .clk(clk), .reset(reset), .cur_rx(cur_rx), .cur_ry(cur_ry),
    .in_valid(in_valid), .in_ready(ad_in_ready), .in_e_addr(in_e_addr), .in_tag(in_tag),
    .out_valid(ad_out_valid), .out_ready(out_ready), .out_destp(ad_out_destp),
    .out_localp(ad_out_localp), .out_dist(ad_out_dist), .out_tag(ad_out_tag), .out_err(ad_out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Vectors at cur=(1,2): ex, ey, ep, XY code, adaptive code, localp, distance
  localparam int NV = 8;
  logic [1:0] v_ex  [NV] = '{2'd3, 2'd1, 2'd0, 2'd1, 2'd3, 2'd2, 2'd0, 2'd1};
  logic [1:0] v_ey  [NV] = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [2:0] v_ep  [NV] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd2, 3'd1, 3'd4};
  logic [3:0] v_xy  [NV] = '{4'b1010, 4'b0101, 4'b0010, 4'b0000, 4'b1010, 4'b1010, 4'b0010, 4'b0001};
  logic [3:0] v_ad  [NV] = '{4'b1010, 4'b0101, 4'b0011, 4'b0000, 4'b1111, 4'b1111, 4'b0010, 4'b0001};
  logic [2:0] v_lp  [NV] = '{3'd0, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
  logic [3:0] v_dst [NV] = '{4'd3, 4'd3, 4'd3, 4'd1, 4'd5, 4'd3, 4'd2, 4'd2};

  initial begin
    reset = 1'b1; cur_rx = 2'd1; cur_ry = 2'd2;
    in_valid = 1'b0; in_e_addr = '0; in_tag = '0; out_ready = 1'b0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_destp", 32'(out_destp), 32'd0);
    check("rst_ad_out_valid", 32'(ad_out_valid), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_rel_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream, result of vector i-1 visible after edge i
    out_ready = 1'b1;
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) begin
        in_valid  = 1'b1;
        in_e_addr = {v_ep[i], v_ey[i], v_ex[i]};
        in_tag    = 4'(i + 3);
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (i == 0) begin
        check("lat_one_cycle_valid", 32'(out_valid), 32'd0);
      end else begin
        check($sformatf("v%0d_valid", i-1), 32'(out_valid), 32'd1);
        check($sformatf("v%0d_destp", i-1), 32'(out_destp), 32'(v_xy[i-1]));
        check($sformatf("v%0d_ad_destp", i-1), 32'(ad_out_destp), 32'(v_ad[i-1]));
        check($sformatf("v%0d_localp", i-1), 32'(out_localp), 32'(v_lp[i-1]));
        check($sformatf("v%0d_dist", i-1), 32'(out_dist), 32'(v_dst[i-1]));
        check($sformatf("v%0d_tag", i-1), 32'(out_tag), 32'(i + 2));
        check($sformatf("v%0d_err", i-1), 32'(out_err), 32'd0);
      end
    end
    @(posedge clk); #1;
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: two fill the pipe, third stalls until out_ready returns
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_e_addr = {3'd0, 2'd2, 2'd3};
    in_tag    = 4'hA;
    check("bp_a_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_tag = 4'hB;
    check("bp_b_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_tag = 4'hC;
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_valid", 32'(out_valid), 32'd1);
    check("bp_hold_tag0", 32'(out_tag), 32'hA);
    @(posedge clk); #1;
    check("bp_hold_tag1", 32'(out_tag), 32'hA);
    check("bp_hold_destp", 32'(out_destp), 32'b1010);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("bp_comb_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_tag_b", 32'(out_tag), 32'hB);
    @(posedge clk); #1;
    check("bp_tag_c", 32'(out_tag), 32'hC);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("bp_empty", 32'(out_valid), 32'd0);

    // Endpoint port beyond P-1 at the local router
    in_valid  = 1'b1;
    in_e_addr = {3'd5, 2'd2, 2'd1};
    in_tag    = 4'h5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("oor_valid", 32'(out_valid), 32'd1);
    check("oor_dist", 32'(out_dist), 32'd1);
`ifdef FMESH_DESTP_ERR_EN
    check("oor_err", 32'(out_err), 32'd1);
    check("oor_destp", 32'(out_destp), 32'd0);
    check("oor_localp", 32'(out_localp), 32'd0);
`else
    check("oor_err", 32'(out_err), 32'd0);
    check("oor_destp", 32'(out_destp), 32'd0);
    check("oor_localp", 32'(out_localp), 32'd5);
`endif

    // Reset with two requests in flight
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_e_addr = {3'd0, 2'd0, 2'd1};
    in_tag    = 4'h1;
    @(posedge clk); #1;
    in_tag = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("flush_valid%0d", i), 32'(out_valid), 32'd0);
    end
    check("flush_ready", 32'(in_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
